ssd_scan_reader: RTL

- Read side of the four one-hot-selected digit memories (slot k is the memory written when sel == 4'b0001<<k).
- Time-multiplexes the four stored 4-bit digits onto one common-anode 4-digit seven-segment display.
- Provides scan prescaling, hex decode, per-digit decimal point, leading-zero blanking and per-digit blink.
- Sits between the digit memories and the FPGA display pins.

---
 rtl/ssd_scan_reader.sv | 161 ++++++++++++++++
 1 files changed

// File: rtl/ssd_scan_reader.sv
// Read side of four digit memories: scans them onto a common-anode 4-digit
// seven-segment display with hex decode, decimal points, leading-zero blanking and blink.
module ssd_scan_reader #(
    parameter int SCAN_DIV    = 100000,
    parameter int BLINK_TICKS = 256
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] digit3,
    input  logic [3:0] digit2,
    input  logic [3:0] digit1,
    input  logic [3:0] digit0,
    input  logic [3:0] dp_en,
    input  logic       lz_en,
    input  logic [3:0] blink_en,
    output logic [3:0] ssd_ctl,
    output logic [7:0] ssd_out
);

    localparam int CNT_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int BLK_W = (BLINK_TICKS > 1) ? $clog2(BLINK_TICKS) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SCAN_DIV - 1);
    localparam logic [BLK_W-1:0] BLK_LAST = BLK_W'(BLINK_TICKS - 1);

    typedef enum logic [1:0] {S0, S1, S2, S3} scan_state_t;

    logic [CNT_W-1:0] r_cnt;
    logic             w_scan_tick;
    scan_state_t      r_state;
    scan_state_t      w_state_nxt;
    logic [BLK_W-1:0] r_blink_cnt;
    logic             r_phase;
    logic [1:0]       w_idx;
    logic [3:0]       w_digit;
    logic             w_dp_en;
    logic             w_blink_en;
    logic             w_lead_zero;
    logic             w_blank;
    logic [6:0]       w_seg;
    logic [3:0]       r_ssd_ctl;
    logic [7:0]       r_ssd_out;

    assign w_scan_tick = (r_cnt == CNT_LAST);

    // NOTE: sequential state uses non-blocking (<=) so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_cnt <= '0;
        end else if (w_scan_tick) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= S0;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // NOTE: every always_comb output is given a default first, so no path can infer a latch.
    always_comb begin
        w_state_nxt = r_state;
        w_idx       = 2'd0;
        w_digit     = digit0;
        w_dp_en     = dp_en[0];
        w_blink_en  = blink_en[0];
        w_lead_zero = 1'b0;
        case (r_state)
            S0: begin
                if (w_scan_tick) w_state_nxt = S1;
            end
            S1: begin
                if (w_scan_tick) w_state_nxt = S2;
                w_idx       = 2'd1;
                w_digit     = digit1;
                w_dp_en     = dp_en[1];
                w_blink_en  = blink_en[1];
                w_lead_zero = (digit3 == 4'd0) && (digit2 == 4'd0) && (digit1 == 4'd0);
            end
            S2: begin
                if (w_scan_tick) w_state_nxt = S3;
                w_idx       = 2'd2;
                w_digit     = digit2;
                w_dp_en     = dp_en[2];
                w_blink_en  = blink_en[2];
                w_lead_zero = (digit3 == 4'd0) && (digit2 == 4'd0);
            end
            S3: begin
                if (w_scan_tick) w_state_nxt = S0;
                w_idx       = 2'd3;
                w_digit     = digit3;
                w_dp_en     = dp_en[3];
                w_blink_en  = blink_en[3];
                w_lead_zero = (digit3 == 4'd0);
            end
            default: w_state_nxt = S0;
        endcase
    end

    // Blink phase advances on scan ticks only; phase 1 is the dark half-period.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_blink_cnt <= '0;
            r_phase     <= 1'b0;
        end else if (w_scan_tick) begin
            if (r_blink_cnt == BLK_LAST) begin
                r_blink_cnt <= '0;
                r_phase     <= ~r_phase;
            end else begin
                r_blink_cnt <= r_blink_cnt + BLK_W'(1);
            end
        end
    end

    assign w_blank = (w_blink_en && r_phase) || (lz_en && w_lead_zero);

    always_comb begin
        w_seg = 7'b1111111;
        case (w_digit)
            4'h0: w_seg = 7'b0000001;
            4'h1: w_seg = 7'b1001111;
            4'h2: w_seg = 7'b0010010;
            4'h3: w_seg = 7'b0000110;
            4'h4: w_seg = 7'b1001100;
            4'h5: w_seg = 7'b0100100;
            4'h6: w_seg = 7'b0100000;
            4'h7: w_seg = 7'b0001111;
            4'h8: w_seg = 7'b0000000;
            4'h9: w_seg = 7'b0000100;
            4'hA: w_seg = 7'b0001000;
            4'hB: w_seg = 7'b1100000;
            4'hC: w_seg = 7'b0110001;
            4'hD: w_seg = 7'b1000010;
            4'hE: w_seg = 7'b0110000;
            4'hF: w_seg = 7'b0111000;
            default: w_seg = 7'b1111111;
        endcase
    end

    // Registered pin drivers: a single anode low per lit slot, everything dark when blanked.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_ssd_ctl <= 4'b1111;
            r_ssd_out <= 8'hFF;
        end else if (w_blank) begin
            r_ssd_ctl <= 4'b1111;
            r_ssd_out <= 8'hFF;
        end else begin
            r_ssd_ctl <= ~(4'b0001 << w_idx);
            r_ssd_out <= {w_seg, ~w_dp_en};
        end
    end

    assign ssd_ctl = r_ssd_ctl;
    assign ssd_out = r_ssd_out;

endmodule
